imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Two-requester arbiter and sequencer for one single-port synchronous memory (mem_sync_sp). It shares that memory between the instruction-fetch stage (read-only) and the data-memory stage (read/write), so the pipeline can run from a unified code/data array. It grants at most one access per cycle and returns read data one cycle later to the owning requester. It also bounds fetch starvation and supports cancelling an in-flight fetch on a redirect.

## Interface
Parameters:
- ADDR_WIDTH, 11, word address width (matches memory DEPTH 2048)
- DATA_WIDTH, 32, memory word width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (legal range 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request, held until granted
- if_addr  in  ADDR_WIDTH  fetch word address
- if_kill  in  1  drop fetch response currently in flight
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = write, 0 = read
- d_be  in  DATA_WIDTH/8  byte enables for writes
- d_addr  in  ADDR_WIDTH  data word address
- d_wdata  in  DATA_WIDTH  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid (reads only)
- d_rdata  out  DATA_WIDTH  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read strobe

## Operation
- Grant is combinational from the requests and registered state:
  - only one request → grant it
  - both requests → data wins, unless starve_cnt == STARVE_LIMIT, then fetch wins
- Exactly one of if_gnt/d_gnt may be high in a cycle. mem_en = if_gnt | d_gnt.
- Memory address mux:
  - fetch grant → mem_addr = if_addr, mem_we = 0, mem_be = 0
  - data grant → d_addr, mem_we = d_we, mem_be = d_be (forced 0 on reads), mem_wdata = d_wdata
  - idle → all mem outputs 0
- starve_cnt is 4 bits:
  - increments, saturating at STARVE_LIMIT, on cycles with if_req & !if_gnt
  - clears on if_gnt or !if_req
- Response tracker is registered:
  - rsel_if ← if_gnt & !if_kill
  - rsel_d ← d_gnt & !d_we
- Next cycle: if_rvalid = rsel_if & !if_kill, d_rvalid = rsel_d. if_kill is honoured both in the issue cycle and in the response cycle.
- if_rdata and d_rdata are driven directly from mem_rdata. They are meaningful only while the matching rvalid is high.
- Data writes complete at grant. No response is generated for a write.
- Requester contract: address, data and we stay stable while req is high and gnt is low. The arbiter does not check this contract.

## Timing
- Grant latency: 0 cycles (same cycle as req when it wins).
- Read latency: rvalid exactly 1 cycle after gnt. Throughput: 1 access per cycle, back-to-back grants allowed.
- Worst-case fetch wait under continuous data traffic is STARVE_LIMIT cycles. The steady-state grant pattern is STARVE_LIMIT data grants, then 1 fetch grant.
- Reset values (while rst_ low and immediately after):
  - if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_be = 0
  - mem_addr, mem_wdata = 0
  - starve_cnt, rsel_if, rsel_d = 0
- Grants are gated off by rst_ low.
- Reset asserted mid-transaction: the in-flight response is discarded and no rvalid appears after release.
- Simultaneous events:
  - A grant in cycle N and the response for cycle N-1 coexist. The tracker updates and the response are independent.
  - if_kill in the same cycle as a new if_gnt still grants (memory is accessed) but suppresses that response.
- Data write followed by data read to the same address in the next cycle returns the new data, per mem_sync_sp write-then-read semantics.

## Test plan
- Reset: hold rst_ low with both reqs high → all outputs 0; release → first cycle grants d_gnt.
- Fetch alone: if_req, if_addr=0x010 for 3 cycles → if_gnt each cycle, mem_addr=0x010, if_rvalid on cycles 2–4 with if_rdata = preloaded word at 0x010.
- Contention, STARVE_LIMIT=4: both reqs held 10 cycles → grant sequence D,D,D,D,I,D,D,D,D,I. No cycle has both grants, and no cycle with a request has no grant.
- Write then read: d_we=1, d_be=4'b0011, d_addr=0x020, d_wdata=0xAABBCCDD over old 0x11223344 → no d_rvalid. Following read → d_rvalid next cycle with d_rdata=0x1122CCDD.
- Kill: fetch granted at cycle N with if_kill high in N+1 → if_rvalid stays 0 in N+1. Repeat with if_kill in N → same.
- Async reset mid-read: drop rst_ between grant and response → if_rvalid never asserts. Outputs go 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port (read-only) and the data port (read/write).
// One access per cycle, read data returned one cycle after the grant.
// Fetch starvation is bounded by STARVE_LIMIT, and if_kill drops a fetch response.
module imem_port_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_kill,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       rsel_if_q, rsel_if_d;
    logic       rsel_d_q, rsel_d_d;

    // Grant select: data has priority unless fetch has waited STARVE_LIMIT cycles.
    // Grants are gated by reset so nothing reaches the memory while rst_ is low.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_) begin
            if (if_req && d_req) begin
                if (starve_cnt_q == STARVE_MAX) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Memory port mux; idle and fetch cycles drive zero write controls.
    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_be    = d_we ? d_be : {BE_W{1'b0}};
            mem_wdata = d_wdata;
        end
    end

    // Next-state for the starvation counter and the response tracker.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        rsel_if_d = if_gnt & ~if_kill;
        rsel_d_d  = d_gnt & ~d_we;
    end

    // State registers; reset discards any response in flight.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            starve_cnt_q <= 4'd0;
            rsel_if_q    <= 1'b0;
            rsel_d_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rsel_if_q    <= rsel_if_d;
            rsel_d_q     <= rsel_d_d;
        end
    end

    // Response steering: a kill in the response cycle still suppresses fetch data.
    always_comb begin
        if_rvalid = rsel_if_q & ~if_kill;
        d_rvalid  = rsel_d_q;
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural synchronous memory.
// Stimulus pushes expected read data into per-port queues; a monitor pops
// and compares whenever a response valid is seen.
module tb_imem_port_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_kill = 1'b0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [3:0]    d_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem [0:2047];

    logic [DW-1:0] if_q [$];
    logic [DW-1:0] d_q [$];

    int n_pass = 0;
    int n_total = 0;

    imem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_(rst_),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with byte-enabled writes, 1-cycle read.
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'hC0DE0000 | i;
        mem[11'h020] = 32'h11223344;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every response valid.
    initial begin
        forever begin
            @(negedge clk);
            if (if_rvalid === 1'b1) begin
                check("if_rvalid_expected", 32'(if_q.size() != 0), 32'd1);
                if (if_q.size() != 0) check("if_rdata", if_rdata, if_q.pop_front());
            end
            if (d_rvalid === 1'b1) begin
                check("d_rvalid_expected", 32'(d_q.size() != 0), 32'd1);
                if (d_q.size() != 0) check("d_rdata", d_rdata, d_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    string seq;

    initial begin
        // Reset with both requests pending.
        if_req = 1'b1; if_addr = 11'h040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 11'h030;
        step(); step();
        check("rst_gnts", {30'd0, if_gnt, d_gnt}, 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_ctrl", {mem_we, mem_be, mem_addr, 16'd0}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        rst_ = 1'b1;
        #1;
        check("post_rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
        d_q.push_back(32'hC0DE0030);
        step();
        if_req = 1'b0; d_req = 1'b0;

        // Fetch alone, three back-to-back grants.
        for (int i = 0; i < 4; i++) begin
            step();
            if_req = (i < 3); if_addr = 11'h010;
            #1;
            if (i < 3) begin
                check("fetch_gnt", {30'd0, if_gnt, d_gnt}, 32'd2);
                check("fetch_addr", 32'(mem_addr), 32'h010);
                check("fetch_we_be", {27'd0, mem_we, mem_be}, 32'd0);
                if_q.push_back(32'hC0DE0010);
            end
            if (i > 0) check("fetch_rvalid", 32'(if_rvalid), 32'd1);
        end

        // Contention: expect D,D,D,D,I repeated.
        seq = "";
        for (int i = 0; i < 10; i++) begin
            step();
            if_req = 1'b1; if_addr = 11'h040;
            d_req = 1'b1; d_we = 1'b0; d_addr = 11'h030;
            #1;
            check("cont_onehot", 32'(if_gnt + d_gnt), 32'd1);
            if ((i % 5) == 4) begin
                check("cont_fetch_win", {30'd0, if_gnt, d_gnt}, 32'd2);
                check("cont_addr_i", 32'(mem_addr), 32'h040);
                if_q.push_back(32'hC0DE0040);
            end else begin
                check("cont_data_win", {30'd0, if_gnt, d_gnt}, 32'd1);
                check("cont_addr_d", 32'(mem_addr), 32'h030);
                d_q.push_back(32'hC0DE0030);
            end
        end
        step();
        if_req = 1'b0; d_req = 1'b0;

        // Partial write then read-back of the same word.
        step();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 11'h020; d_wdata = 32'hAABBCCDD;
        #1;
        check("wr_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
        check("wr_ctrl", {27'd0, mem_we, mem_be}, 32'h13);
        check("wr_wdata", mem_wdata, 32'hAABBCCDD);
        step();
        d_we = 1'b0; d_be = 4'b1111;
        #1;
        check("wr_no_rvalid", 32'(d_rvalid), 32'd0);
        check("rd_ctrl", {27'd0, mem_we, mem_be}, 32'd0);
        d_q.push_back(32'h1122CCDD);
        step();
        d_req = 1'b0;
        #1;
        check("rd_rvalid", 32'(d_rvalid), 32'd1);

        // Kill in the response cycle.
        step();
        if_req = 1'b1; if_addr = 11'h010;
        #1;
        check("killN1_gnt", 32'(if_gnt), 32'd1);
        step();
        if_req = 1'b0; if_kill = 1'b1;
        #1;
        check("killN1_rvalid", 32'(if_rvalid), 32'd0);
        step();
        if_kill = 1'b0;

        // Kill in the issue cycle: memory is still accessed.
        step();
        if_req = 1'b1; if_kill = 1'b1;
        #1;
        check("killN_gnt", {31'd0, if_gnt}, 32'd1);
        check("killN_mem_en", 32'(mem_en), 32'd1);
        step();
        if_req = 1'b0; if_kill = 1'b0;
        #1;
        check("killN_rvalid", 32'(if_rvalid), 32'd0);

        // Async reset between grant and response.
        step();
        if_req = 1'b1; if_addr = 11'h010;
        #1;
        check("arst_gnt", 32'(if_gnt), 32'd1);
        #1;
        rst_ = 1'b0;
        #1;
        check("arst_gnt_off", {30'd0, if_gnt, mem_en}, 32'd0);
        step();
        check("arst_rvalid_in_rst", 32'(if_rvalid), 32'd0);
        if_req = 1'b0;
        rst_ = 1'b1;
        step();
        check("arst_rvalid_after", 32'(if_rvalid), 32'd0);

        step(); step(); step();
        check("if_queue_drained", 32'(if_q.size()), 32'd0);
        check("d_queue_drained", 32'(d_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
